fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined CPU, sitting directly upstream of `Decode`. It owns the program counter and drives a synchronous-read instruction memory (1-cycle read latency). It presents the fetched instruction and its PC to `Decode` on `if_idata_out` / `if_pc_out`. It handles pipeline stall, branch/jump redirect with flush, and inserts NOP bubbles.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `NOP_INSTR`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `if_stall_in` input 1: hold the PC and the IF/ID register (load-use hazard from the hazard unit).
- `if_redirect_in` input 1: a taken branch/jump was resolved in EX; flush and refetch.
- `if_target_in` input 32: redirect target; bits [1:0] ignored (forced 0).
- `imem_addr_out` output 32: instruction memory read address, combinational.
- `imem_rdata_in` input 32: instruction at the address presented on the previous cycle.
- `if_idata_out` output 32: registered instruction to `Decode`.
- `if_pc_out` output 32: registered PC of `if_idata_out`.
- `if_valid_out` output 1: registered; 0 marks a bubble.
- `if_pred_taken_out` output 1: registered; the instruction was a JAL already followed by fetch (only with the macro; otherwise constant 0).

## Operation
- Internal state: `pc` (32b, address whose data is on `imem_rdata_in` this cycle) and a 2-state FSM, BOOT and RUN.
- BOOT (entered on reset): `imem_addr_out = pc = RESET_PC`. The IF/ID register loads a bubble. Next state is RUN. `imem_rdata_in` is ignored in BOOT.
- RUN, next-address priority (highest first):
  - `if_redirect_in`: `imem_addr_out = {if_target_in[31:2],2'b00}`. IF/ID loads a bubble (kills the wrong-path instruction arriving now). `pc` is loaded with the target.
  - `if_stall_in`: `imem_addr_out = pc`, so the same word re-arrives next cycle. `pc` and the IF/ID register hold.
  - JAL predict (macro only): `imem_addr_out = pc + jimm`, where jimm is the sign-extended J-immediate of `imem_rdata_in`. IF/ID loads that instruction with `if_pred_taken_out=1`.
  - Default: `imem_addr_out = pc + 4`. IF/ID loads `{imem_rdata_in, pc, valid=1, pred=0}`.
- In every non-stall case, `pc <= imem_addr_out`.
- Bubble = `{NOP_INSTR, pc, valid=0, pred=0}`.
- Redirect and stall in the same cycle: redirect wins; the stall is dropped for this cycle.
- Redirect in BOOT: takes effect. `pc` is loaded with the target and the FSM goes to RUN.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Reset mid-operation discards all in-flight state; behaviour is identical to power-on reset.

## Timing
- Reset values: `if_idata_out=NOP_INSTR`, `if_pc_out=RESET_PC`, `if_valid_out=0`, `if_pred_taken_out=0`, `pc=RESET_PC`, FSM=BOOT. While `reset` is high, `imem_addr_out=RESET_PC`.
- Latency: address presented in cycle t, data in cycle t+1, visible on `if_idata_out` in cycle t+2.
- Redirect penalty: with redirect asserted in cycle t, the target instruction is on `if_idata_out` in cycle t+2, preceded by one bubble (cycle t+1).
- Throughput: 1 instruction/cycle with no stall or redirect.
- Stall held for N cycles freezes the outputs for N cycles. The first new instruction appears the cycle after stall deasserts.

## Configuration
- `FETCH_JAL_PREDECODE_EN` defined:
  - JAL (opcode 7'b1101111) on `imem_rdata_in` in RUN, with no stall or redirect, steers fetch to its target with no bubble.
  - `if_pred_taken_out=1` tells EX to suppress the redirect for that JAL.
- Undefined: no predecode logic. `if_pred_taken_out` is tied to 0 and JAL is resolved by the EX redirect like any branch.

## Structure
- Shared package `cpu_pkg`:
  - `NOP_INSTR` value.
  - Opcode constant `OP_JAL`.
  - Typedef `if_id_t` {idata, pc, valid, pred_taken}.
- One sub-module, `jal_predecode`: combinational; input instruction; outputs `is_jal` and the 32b sign-extended J-immediate. Instantiated only under `FETCH_JAL_PREDECODE_EN`.

## Test plan
- Reset then free run, memory word i = 32'h1000_0000+i: first valid output is idata 32'h1000_0000, pc 0 at cycle 2; then consecutive PCs 4, 8, 12 every cycle.
- Stall for 3 cycles while `if_pc_out=8`: outputs hold pc 8 for 3 cycles; pc 12 appears the cycle after release; no instruction skipped or duplicated.
- Redirect to 32'h0000_0100 while `if_pc_out=12`: next cycle is a bubble (valid 0, idata 32'h13); following cycle is pc 32'h100.
- Redirect and stall asserted together, target 32'h40: redirect wins; bubble, then pc 32'h40.
- Macro on, JAL at 32'h10 with imm +32: next valid pc is 32'h30 with no bubble, and `pred_taken=1` on the JAL. Macro off: next pc is 32'h14.
- Reset asserted mid-run at pc 32'h200: outputs return to reset values in the next cycle; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bubble instruction, opcodes, fetch FSM states and the IF/ID record.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] idata;
        logic [31:0] pc;
        logic        valid;
        logic        pred_taken;
    } if_id_t;

endpackage

// File: rtl/jal_predecode.sv
// Combinational JAL detector; extracts the sign-extended J-type immediate.
module jal_predecode
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_jal,
    output logic [31:0] jimm
);

    // rd is irrelevant to steering fetch
    logic unused_rd_bits;

    assign unused_rd_bits = ^instr[11:7];
    assign is_jal = (instr[6:0] == OP_JAL);
    assign jimm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, IF/ID register, stall/redirect handling.
// Optional JAL predecode steering is enabled by defining FETCH_JAL_PREDECODE_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_stall_in,
    input  logic         if_redirect_in,
    input  logic [31:0]  if_target_in,
    output logic [31:0]  imem_addr_out,
    input  logic [31:0]  imem_rdata_in,
    output logic [31:0]  if_idata_out,
    output logic [31:0]  if_pc_out,
    output logic         if_valid_out,
    output logic         if_pred_taken_out,
    output fetch_state_e dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  next_addr;
    logic [31:0]  target_al;
    logic         hold;
    if_id_t       if_id_q, if_id_d, bubble;

    assign target_al = if_target_in & ~32'h0000_0003;
    assign bubble    = '{idata: NOP_INSTR, pc: pc_q, valid: 1'b0, pred_taken: 1'b0};

`ifdef FETCH_JAL_PREDECODE_EN
    logic        is_jal;
    logic [31:0] jimm;

    jal_predecode u_predecode (
        .instr  (imem_rdata_in),
        .is_jal (is_jal),
        .jimm   (jimm)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT) state_d = ST_RUN;
    end

    // Next fetch address and IF/ID load value; redirect beats stall.
    always_comb begin
        next_addr = RESET_PC;
        if_id_d   = bubble;
        hold      = 1'b0;
        if (reset) begin
            next_addr = RESET_PC;
        end else if (state_q == ST_BOOT) begin
            next_addr = if_redirect_in ? target_al : RESET_PC;
        end else if (if_redirect_in) begin
            next_addr = target_al;
        end else if (if_stall_in) begin
            next_addr = pc_q;
            hold      = 1'b1;
            if_id_d   = if_id_q;
`ifdef FETCH_JAL_PREDECODE_EN
        end else if (is_jal) begin
            next_addr = pc_q + jimm;
            if_id_d   = '{idata: imem_rdata_in, pc: pc_q, valid: 1'b1, pred_taken: 1'b1};
`endif
        end else begin
            next_addr = pc_q + 32'd4;
            if_id_d   = '{idata: imem_rdata_in, pc: pc_q, valid: 1'b1, pred_taken: 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            if_id_q <= '{idata: NOP_INSTR, pc: RESET_PC, valid: 1'b0, pred_taken: 1'b0};
        end else begin
            if (!hold) pc_q <= next_addr;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr_out     = next_addr;
    assign if_idata_out      = if_id_q.idata;
    assign if_pc_out         = if_id_q.pc;
    assign if_valid_out      = if_id_q.valid;
    assign if_pred_taken_out = if_id_q.pred_taken;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle expected IF/ID outputs queued and compared.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_stall_in;
    logic         if_redirect_in;
    logic [31:0]  if_target_in;
    logic [31:0]  imem_addr_out;
    logic [31:0]  imem_rdata_in;
    logic [31:0]  if_idata_out;
    logic [31:0]  if_pc_out;
    logic         if_valid_out;
    logic         if_pred_taken_out;
    fetch_state_e dbg_state;

    bit           jal_flag;
    int           n_checks;
    int           n_pass;
    logic [65:0]  exp_q[$];

    localparam logic [31:0] JAL_P32 = 32'h0200_006F;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_stall_in       (if_stall_in),
        .if_redirect_in    (if_redirect_in),
        .if_target_in      (if_target_in),
        .imem_addr_out     (imem_addr_out),
        .imem_rdata_in     (imem_rdata_in),
        .if_idata_out      (if_idata_out),
        .if_pc_out         (if_pc_out),
        .if_valid_out      (if_valid_out),
        .if_pred_taken_out (if_pred_taken_out),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: word i holds 32'h1000_0000 + i, optional JAL at 0x10
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (jal_flag && addr == 32'h10) return JAL_P32;
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    always @(posedge clk) imem_rdata_in <= mem_word(imem_addr_out);

    function automatic logic [65:0] mk(input logic p, input logic v, input logic [31:0] pc, input logic [31:0] d);
        return {p, v, pc, d};
    endfunction

    function automatic logic [65:0] dut_out();
        return {if_pred_taken_out, if_valid_out, if_pc_out, if_idata_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_stall_in = 1'b0; if_redirect_in = 1'b0;
        if_target_in = 32'h0; jal_flag = 1'b0;
        tick(); tick();
        n_checks++; if (if_idata_out === NOP_INSTR) n_pass++;
        else $display("FAIL reset_idata: got %h exp %h", if_idata_out, NOP_INSTR);
        n_checks++; if (if_pc_out === 32'h0) n_pass++;
        else $display("FAIL reset_pc: got %h exp 0", if_pc_out);
        n_checks++; if (if_valid_out === 1'b0 && if_pred_taken_out === 1'b0) n_pass++;
        else $display("FAIL reset_flags: got v=%b p=%b exp 0 0", if_valid_out, if_pred_taken_out);
        n_checks++; if (imem_addr_out === 32'h0) n_pass++;
        else $display("FAIL reset_addr: got %h exp 0", imem_addr_out);
        n_checks++; if (dbg_state === ST_BOOT) n_pass++;
        else $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_BOOT);
    endtask

    task automatic test_free_run();
        logic [65:0] got, exp;
        exp_q.push_back(mk(0, 0, 32'h0, NOP_INSTR));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 1, 32'(i * 4), mem_word(32'(i * 4))));
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL free_run[%0d]: got %h exp %h", c, got, exp);
        end
    endtask

    task automatic test_stall();
        logic [65:0] got, exp;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 1, 32'h8, mem_word(32'h8)));
        exp_q.push_back(mk(0, 1, 32'hC, mem_word(32'hC)));
        for (int c = 0; c < 4; c++) begin
            if_stall_in = (c < 3);
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL stall[%0d]: got %h exp %h", c, got, exp);
            if (c < 2) begin
                n_checks++; if (imem_addr_out === 32'hC) n_pass++;
                else $display("FAIL stall_addr[%0d]: got %h exp c", c, imem_addr_out);
            end
        end
        if_stall_in = 1'b0;
    endtask

    task automatic test_redirect();
        logic [65:0] got, exp;
        exp_q.push_back(mk(0, 0, 32'h10, NOP_INSTR));
        exp_q.push_back(mk(0, 1, 32'h100, mem_word(32'h100)));
        exp_q.push_back(mk(0, 1, 32'h104, mem_word(32'h104)));
        for (int c = 0; c < 3; c++) begin
            if_redirect_in = (c == 0);
            if_target_in = 32'h100;
            if (c == 0) begin
                #1;
                n_checks++; if (imem_addr_out === 32'h100) n_pass++;
                else $display("FAIL redirect_addr: got %h exp 100", imem_addr_out);
            end
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL redirect[%0d]: got %h exp %h", c, got, exp);
        end
    endtask

    task automatic test_redirect_stall();
        logic [65:0] got, exp;
        exp_q.push_back(mk(0, 0, 32'h108, NOP_INSTR));
        exp_q.push_back(mk(0, 1, 32'h40, mem_word(32'h40)));
        exp_q.push_back(mk(0, 1, 32'h44, mem_word(32'h44)));
        for (int c = 0; c < 3; c++) begin
            if_redirect_in = (c == 0);
            if_stall_in = (c == 0);
            if_target_in = 32'h40;
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL redirect_stall[%0d]: got %h exp %h", c, got, exp);
        end
    endtask

    task automatic test_wrap();
        logic [65:0] got, exp;
        exp_q.push_back(mk(0, 0, 32'h48, NOP_INSTR));
        exp_q.push_back(mk(0, 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)));
        exp_q.push_back(mk(0, 1, 32'h0, mem_word(32'h0)));
        exp_q.push_back(mk(0, 1, 32'h4, mem_word(32'h4)));
        for (int c = 0; c < 4; c++) begin
            if_redirect_in = (c == 0);
            if_target_in = 32'hFFFF_FFFF;
            if (c == 0) begin
                #1;
                n_checks++; if (imem_addr_out === 32'hFFFF_FFFC) n_pass++;
                else $display("FAIL wrap_align: got %h exp fffffffc", imem_addr_out);
            end
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL wrap[%0d]: got %h exp %h", c, got, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [65:0] got, exp;
        exp_q.push_back(mk(0, 0, 32'h8, NOP_INSTR));
        exp_q.push_back(mk(0, 1, 32'h200, mem_word(32'h200)));
        exp_q.push_back(mk(0, 0, 32'h0, NOP_INSTR));
        exp_q.push_back(mk(0, 0, 32'h0, NOP_INSTR));
        exp_q.push_back(mk(0, 1, 32'h0, mem_word(32'h0)));
        exp_q.push_back(mk(0, 1, 32'h4, mem_word(32'h4)));
        for (int c = 0; c < 6; c++) begin
            if_redirect_in = (c == 0);
            if_target_in = 32'h200;
            reset = (c == 2);
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL mid_reset[%0d]: got %h exp %h", c, got, exp);
            if (c == 2) begin
                n_checks++; if (imem_addr_out === 32'h0 && dbg_state === ST_BOOT) n_pass++;
                else $display("FAIL mid_reset_addr: got addr %h state %0d exp 0 0", imem_addr_out, dbg_state);
            end
        end
    endtask

    task automatic test_jal();
        logic [65:0] got, exp;
        logic        pred;
        int          c;
`ifdef FETCH_JAL_PREDECODE_EN
        pred = 1'b1;
`else
        pred = 1'b0;
`endif
        reset = 1'b1; jal_flag = 1'b1; if_redirect_in = 1'b0; if_stall_in = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_q.push_back(mk(0, 0, 32'h0, NOP_INSTR));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 1, 32'(i * 4), mem_word(32'(i * 4))));
        exp_q.push_back(mk(pred, 1, 32'h10, JAL_P32));
        if (pred) begin
            exp_q.push_back(mk(0, 1, 32'h30, mem_word(32'h30)));
            exp_q.push_back(mk(0, 1, 32'h34, mem_word(32'h34)));
        end else begin
            exp_q.push_back(mk(0, 1, 32'h14, mem_word(32'h14)));
            exp_q.push_back(mk(0, 1, 32'h18, mem_word(32'h18)));
        end
        c = 0;
        while (exp_q.size() > 0) begin
            tick();
            got = dut_out(); exp = exp_q.pop_front(); n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL jal[%0d]: got %h exp %h", c, got, exp);
            c++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_mid_reset();
        test_jal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
